ram_bidir_be: RTL and testbench

- Parametrised single-port synchronous RAM with a shared bidirectional data bus. Successor to the 32x32 ram2 block.
- Adds generic width/depth, byte write enables, registered read with a valid flag, and a post-reset zero-fill sweep.
- Sits between the lab CPU/datapath and its tristate data bus. The master drives the bus on writes; this block drives it on reads.

---
 rtl/ram_bidir_be.sv | 125 ++++++++++++
 tb/tb_ram_bidir_be.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_bidir_be.sv
// ram_bidir_be: single-port RAM on a shared tristate bus, byte enables,
// registered read, post-reset zero-fill. Option: RAM_BIDIR_PARITY_EN.
module ram_bidir_be #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int BE_W   = DATA_W/8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              wena,
  input  logic [BE_W-1:0]   be,
  input  logic [ADDR_W-1:0] addr,
  inout  wire  [DATA_W-1:0] data_io,
  output logic              busy,
  output logic              rvalid,
  output logic              perr
);

  localparam int DEPTH = 2**ADDR_W;
`ifdef RAM_BIDIR_PARITY_EN
  localparam int MEM_W = DATA_W + BE_W;
`else
  localparam int MEM_W = DATA_W;
`endif

  typedef enum logic {S_CLEAR, S_IDLE} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [MEM_W-1:0]  mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              wr, rd;
  logic [MEM_W-1:0]  rword;
  logic [MEM_W-1:0]  wword;

  assign busy  = (state_q == S_CLEAR);
  assign wr    = ena & wena & ~busy;
  assign rd    = ena & ~wena & ~busy;
  assign rword = mem_q[addr];

  // Sweep counter walks every word once, then parks in IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == S_CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      if (&cnt_q) state_d = S_IDLE;
    end
  end

  // FSM and clear counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Merge enabled bytes of the bus into the addressed word.
  always_comb begin
    wword = rword;
    for (int i = 0; i < BE_W; i++) begin
      if (be[i]) begin
        wword[8*i +: 8] = data_io[8*i +: 8];
`ifdef RAM_BIDIR_PARITY_EN
        wword[DATA_W+i] = ^data_io[8*i +: 8];
`endif
      end
    end
  end

  // Storage: zero-fill during the sweep, byte-merged writes afterwards.
  always_ff @(posedge clk) begin
    if (busy) mem_q[cnt_q] <= '0;
    else if (wr) mem_q[addr] <= wword;
  end

  // Read data holds its value between reads; valid tracks acceptance.
  always_comb begin
    rvalid_d = rd;
    rdata_d  = rd ? rword[DATA_W-1:0] : rdata_q;
  end

  // Read register and valid flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

`ifdef RAM_BIDIR_PARITY_EN
  logic perr_q, perr_d;

  // Any byte whose stored parity disagrees flags the read.
  always_comb begin
    perr_d = 1'b0;
    for (int i = 0; i < BE_W; i++) begin
      if (rword[DATA_W+i] != ^rword[8*i +: 8]) perr_d = rd;
    end
  end

  // Parity error register, aligned with rvalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perr_q <= 1'b0;
    else        perr_q <= perr_d;
  end

  assign perr = perr_q;
`else
  assign perr = 1'b0;
`endif

  assign rvalid  = rvalid_q;
  assign data_io = (ena & ~wena & rvalid_q) ? rdata_q : 'z;

endmodule

// File: tb/tb_ram_bidir_be.sv
// tb_ram_bidir_be: randomized and directed bench for ram_bidir_be
// against a word-array reference model.
module tb_ram_bidir_be;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena, wena;
  logic [3:0]  be;
  logic [4:0]  addr;
  logic        drv_en;
  logic [31:0] drv;
  wire  [31:0] data_io;
  logic        busy, rvalid, perr;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] mdl [32];

  assign data_io = drv_en ? drv : 'z;

  always #5 clk = ~clk;

  ram_bidir_be dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .wena(wena), .be(be),
    .addr(addr), .data_io(data_io), .busy(busy), .rvalid(rvalid),
    .perr(perr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ena = 1'b0; wena = 1'b0; be = '0; addr = '0; drv_en = 1'b0; drv = '0;
  endtask

  task automatic mdl_clear();
    for (int i = 0; i < 32; i++) mdl[i] = '0;
  endtask

  task automatic mdl_write(input logic [4:0] a, input logic [3:0] b,
                           input logic [31:0] d);
    logic [31:0] mask;
    mask = '0;
    for (int i = 0; i < 4; i++) if (b[i]) mask = mask | (32'hFF << (8*i));
    mdl[a] = (mdl[a] & ~mask) | (d & mask);
  endtask

  task automatic do_write(input logic [4:0] a, input logic [3:0] b,
                          input logic [31:0] d);
    ena = 1'b1; wena = 1'b1; be = b; addr = a; drv_en = 1'b1; drv = d;
    #1;
    n_cmp++;
    if (data_io !== d) begin
      n_bad++;
      $display("FAIL wr_bus_free a=%0d got %h want %h", a, data_io, d);
    end
    tick();
    mdl_write(a, b, d);
  endtask

  task automatic test_reset();
    int cyc;
    bit done;
    idle();
    mdl_clear();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++; $display("FAIL rst_busy got %b want 1", busy);
    end
    n_cmp++;
    if (rvalid !== 1'b0) begin
      n_bad++; $display("FAIL rst_rvalid got %b want 0", rvalid);
    end
    n_cmp++;
    if (perr !== 1'b0) begin
      n_bad++; $display("FAIL rst_perr got %b want 0", perr);
    end
    rst_n = 1'b1;
    cyc = 0;
    done = 0;
    while (!done && cyc < 100) begin
      if (cyc < 15) begin
        ena = 1'b1; wena = 1'b0; addr = 5'd2; drv_en = 1'b0;
      end else begin
        ena = 1'b1; wena = 1'b1; be = 4'hF; addr = 5'd3;
        drv_en = 1'b1; drv = 32'hDEADBEEF;
      end
      tick();
      cyc++;
      n_cmp++;
      if (rvalid !== 1'b0) begin
        n_bad++; $display("FAIL busy_rvalid cyc=%0d got %b want 0", cyc, rvalid);
      end
      if (busy !== 1'b1) done = 1;
    end
    idle();
    n_cmp++;
    if (cyc != 32) begin
      n_bad++; $display("FAIL clear_len got %0d want 32", cyc);
    end
  endtask

  task automatic test_zero_sweep();
    for (int a = 0; a < 32; a++) begin
      ena = 1'b1; wena = 1'b0; addr = 5'(a); drv_en = 1'b0;
      tick();
      n_cmp++;
      if (rvalid !== 1'b1 || data_io !== mdl[a]) begin
        n_bad++;
        $display("FAIL zero_rd a=%0d got v=%b %h want v=1 %h",
                 a, rvalid, data_io, mdl[a]);
      end
    end
    idle();
    tick();
  endtask

  task automatic rd_check(input string nm, input logic [4:0] a,
                          input logic [31:0] want);
    ena = 1'b1; wena = 1'b0; addr = a; drv_en = 1'b0;
    tick();
    n_cmp++;
    if (rvalid !== 1'b1 || data_io !== want) begin
      n_bad++;
      $display("FAIL %s got v=%b %h want v=1 %h", nm, rvalid, data_io, want);
    end
  endtask

  task automatic test_write_read();
    do_write(5'd4, 4'hF, 32'hFF00FF00);
    rd_check("rd4", 5'd4, 32'hFF00FF00);
    n_cmp++;
    if (mdl[4] !== 32'hFF00FF00) begin
      n_bad++; $display("FAIL mdl4 got %h want ff00ff00", mdl[4]);
    end
    idle();
    tick();
  endtask

  task automatic test_byte_enable();
    do_write(5'd5, 4'hF, 32'hFFFFFFFF);
    do_write(5'd5, 4'b0101, 32'h12345678);
    rd_check("be_rd5", 5'd5, 32'hFF34FF78);
    idle();
    tick();
  endtask

  task automatic test_release();
    rd_check("rel_rd4", 5'd4, 32'hFF00FF00);
    ena = 1'b0; drv_en = 1'b1; drv = 32'h0;
    #1;
    n_cmp++;
    if (data_io !== 32'h0) begin
      n_bad++; $display("FAIL ena_release got %h want 00000000", data_io);
    end
    tick();
    n_cmp++;
    if (rvalid !== 1'b0) begin
      n_bad++; $display("FAIL ena_rvalid got %b want 0", rvalid);
    end
    rd_check("rel_rd4b", 5'd4, 32'hFF00FF00);
    ena = 1'b1; wena = 1'b1; be = 4'h0; addr = 5'd4;
    drv_en = 1'b1; drv = 32'h0;
    #1;
    n_cmp++;
    if (data_io !== 32'h0) begin
      n_bad++; $display("FAIL wena_release got %h want 00000000", data_io);
    end
    tick();
    rd_check("be0_noop", 5'd4, 32'hFF00FF00);
    idle();
    tick();
  endtask

  task automatic test_random();
    logic        exp_v;
    logic [31:0] exp_d;
    logic        r_ena, r_wena;
    logic [3:0]  r_be;
    logic [4:0]  r_a;
    logic [31:0] r_d;
    exp_v = 1'b0;
    exp_d = '0;
    for (int k = 0; k < 400; k++) begin
      r_ena  = ($urandom_range(0, 3) != 0);
      r_wena = 1'($urandom_range(0, 1));
      r_be   = 4'($urandom);
      r_a    = 5'($urandom);
      r_d    = $urandom;
      ena = r_ena; wena = r_wena; be = r_be; addr = r_a;
      drv_en = !(r_ena && !r_wena);
      drv = r_d;
      #1;
      n_cmp++;
      if (rvalid !== exp_v || perr !== 1'b0) begin
        n_bad++;
        $display("FAIL rnd_flags k=%0d got v=%b p=%b want v=%b p=0",
                 k, rvalid, perr, exp_v);
      end
      if (r_ena && !r_wena && exp_v) begin
        n_cmp++;
        if (data_io !== exp_d) begin
          n_bad++;
          $display("FAIL rnd_rdata k=%0d got %h want %h", k, data_io, exp_d);
        end
      end else if (drv_en) begin
        n_cmp++;
        if (data_io !== r_d) begin
          n_bad++;
          $display("FAIL rnd_bus k=%0d got %h want %h", k, data_io, r_d);
        end
      end
      exp_v = r_ena && !r_wena;
      if (exp_v) exp_d = mdl[r_a];
      if (r_ena && r_wena) mdl_write(r_a, r_be, r_d);
      @(posedge clk);
      #1;
    end
    idle();
    tick();
  endtask

  task automatic test_reset_mid_sweep();
    int cyc;
    bit done;
    do_write(5'd4, 4'hF, 32'hA5A5A5A5);
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b1 || rvalid !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_rst got b=%b v=%b want b=1 v=0", busy, rvalid);
    end
    tick();
    rst_n = 1'b1;
    cyc = 0;
    done = 0;
    while (!done && cyc < 100) begin
      tick();
      cyc++;
      if (busy !== 1'b1) done = 1;
    end
    n_cmp++;
    if (cyc != 32) begin
      n_bad++; $display("FAIL mid_clear_len got %0d want 32", cyc);
    end
    mdl_clear();
    rd_check("mid_rd4", 5'd4, mdl[4]);
    rd_check("mid_rd31", 5'd31, mdl[31]);
    idle();
    tick();
  endtask

`ifdef RAM_BIDIR_PARITY_EN
  task automatic test_parity();
    dut.mem_q[7][32] = 1'b1;
    ena = 1'b1; wena = 1'b0; addr = 5'd7; drv_en = 1'b0;
    tick();
    n_cmp++;
    if (rvalid !== 1'b1 || perr !== 1'b1) begin
      n_bad++;
      $display("FAIL par_bad got v=%b p=%b want v=1 p=1", rvalid, perr);
    end
    addr = 5'd8;
    tick();
    n_cmp++;
    if (rvalid !== 1'b1 || perr !== 1'b0) begin
      n_bad++;
      $display("FAIL par_clean got v=%b p=%b want v=1 p=0", rvalid, perr);
    end
    idle();
    tick();
    n_cmp++;
    if (rvalid !== 1'b0 || perr !== 1'b0) begin
      n_bad++;
      $display("FAIL par_idle got v=%b p=%b want v=0 p=0", rvalid, perr);
    end
    do_write(5'd9, 4'h1, 32'h00000001);
    ena = 1'b1; wena = 1'b0; addr = 5'd9; drv_en = 1'b0;
    tick();
    n_cmp++;
    if (perr !== 1'b0 || data_io !== 32'h1) begin
      n_bad++;
      $display("FAIL par_odd got p=%b %h want p=0 00000001", perr, data_io);
    end
    idle();
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_zero_sweep();
    test_write_read();
    test_byte_enable();
    test_release();
    test_random();
    test_reset_mid_sweep();
`ifdef RAM_BIDIR_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
